// File: rtl/sr_pkg.sv
// Shared types and constants for the debounced SR control path.
package sr_pkg;

  typedef enum logic [1:0] {
    ST_LO   = 2'd0,
    WAIT_HI = 2'd1,
    ST_HI   = 2'd2,
    WAIT_LO = 2'd3
  } db_state_t;

  localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/sr_debounce_ch.sv
// One input channel: synchronizer, counter-based debouncer, and accepted-rise pulse.
module sr_debounce_ch
  import sr_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   y;
  db_state_t              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  assign y = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= ST_LO;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // rise is combinational so the top registers it on the same edge the FSM accepts the level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise    = 1'b0;
    case (state_q)
      ST_LO: begin
        if (y) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HI: begin
        if (!y) begin
          state_d = ST_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_HI;
          cnt_d   = '0;
          rise    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HI: begin
        if (!y) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LO: begin
        if (y) begin
          state_d = ST_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_LO;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/sr_debounce_ctrl.sv
// Debounced set/reset pulse generator with reset-priority conflict handling and
// a registered complementary SR state pair.
module sr_debounce_ctrl
  import sr_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_raw,
  input  logic reset_raw,
  output logic s,
  output logic r,
  output logic q,
  output logic q_n,
  output logic conflict
);

  logic set_rise, reset_rise;
  logic s_d, r_d, q_d, conflict_d;

  sr_debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_set_ch (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (set_raw),
    .rise (set_rise)
  );

  sr_debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_reset_ch (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (reset_raw),
    .rise (reset_rise)
  );

  // Reset wins a same-cycle collision so s and r are never high together.
  always_comb begin
    s_d        = set_rise & ~reset_rise;
    r_d        = reset_rise;
    conflict_d = set_rise & reset_rise;
    q_d        = q;
    if (reset_rise) begin
      q_d = 1'b0;
    end else if (set_rise) begin
      q_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s        <= 1'b0;
      r        <= 1'b0;
      conflict <= 1'b0;
      q        <= 1'b0;
      q_n      <= 1'b1;
    end else begin
      s        <= s_d;
      r        <= r_d;
      conflict <= conflict_d;
      q        <= q_d;
      q_n      <= ~q_d;
    end
  end

endmodule

// File: doc/sr_debounce_ctrl.md
Name: sr_debounce_ctrl

Overview:
- Upstream stage that turns two raw, bouncy pushbutton/level inputs (set, reset) into clean single-cycle set/reset pulses.
- Also drives a registered, glitch-free SR state pair (q, q_n) for the gate-level SR storage stage and the indicators behind it.
- Per channel: 2-FF synchronizer, then a counter-based debouncer FSM, then a rising-edge pulse.
- Owns conflict resolution, so the downstream SR stage never sees s and r asserted together.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronized samples of a new level required to accept it; legal range 2..65535.
CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width; derived, not overridden.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
set_raw  input  1  asynchronous, bouncy set request
reset_raw  input  1  asynchronous, bouncy reset request
s  output  1  one-cycle set pulse, drives downstream SR set input
r  output  1  one-cycle reset pulse, drives downstream SR reset input
q  output  1  registered SR state
q_n  output  1  always the complement of q
conflict  output  1  one-cycle flag: set and reset pulses accepted in the same cycle

Behaviour:
- Reset is synchronous and active-low: clk is the only clock, rst_n sampled on its rising edge. While rst_n=0 at an edge:
  - sync flops = 0
  - channel FSMs = ST_LO, counters = 0
  - s = 0, r = 0, conflict = 0, q = 0, q_n = 1
- Reset mid-debounce discards partial counts; no pulse is produced for that attempt.
- Synchronizer: two flops per channel. Sync output y lags the raw input by 2 edges.
- Channel FSM, identical per channel, evaluated each edge on y:
  - ST_LO: y=1 -> WAIT_HI, cnt=1. Otherwise stay.
  - WAIT_HI:
    - y=0 -> ST_LO, cnt=0.
    - y=1 and cnt==DEBOUNCE_CYCLES-1 -> ST_HI, cnt=0, assert channel pulse this edge.
    - Otherwise cnt+1.
  - ST_HI: y=0 -> WAIT_LO, cnt=1. Otherwise stay.
  - WAIT_LO:
    - y=1 -> ST_HI, cnt=0.
    - y=0 and cnt==DEBOUNCE_CYCLES-1 -> ST_LO, cnt=0, no pulse.
    - Otherwise cnt+1.
- Channel pulses are exactly one cycle, and only on the accepted low-to-high transition. A held input never re-pulses.
- Latency: raw held high from before edge k -> pulse visible after edge k+1+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+2 cycles from the first sampling edge.
- Output stage, registered in the same edge as the FSM transition:
  - set pulse only: s=1, q=1.
  - reset pulse only: r=1, q=0.
  - both: reset wins. r=1, s=0, q=0, conflict=1.
  - neither: s=r=conflict=0, q holds.
- q_n is registered alongside q, never combinational, and is always ~q, including in reset.
- s and r are never 1 in the same cycle.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around path exists.
- A bounce shorter than DEBOUNCE_CYCLES samples returns to the prior stable state and produces no pulse.

Decomposition:
- Shared package sr_pkg:
  - db_state_t enum {ST_LO, WAIT_HI, ST_HI, WAIT_LO}, 2-bit encoding.
  - Constant SYNC_STAGES=2.
- One sub-module, sr_debounce_ch: synchronizer + FSM + counter + rise pulse. Parameter DEBOUNCE_CYCLES; ports clk, rst_n, din, rise.
- Instantiated twice. The top holds only the priority/output registers.

Test Plan:
1. Clean set with DEBOUNCE_CYCLES=4: set_raw 0->1 before edge 10, held -> s=1 for exactly the cycle after edge 15; q=1, q_n=0 from edge 15 onward; r=0 throughout.
2. Bounce rejection: set_raw toggles 1,0,1,0 on successive cycles, then settles 0 -> no s pulse; q unchanged.
3. Simultaneous: set_raw and reset_raw rise on the same edge with q=1 -> after 6 cycles r=1, s=0, conflict=1 (single cycle); q=0, q_n=1.
4. Hold and release: reset_raw held 50 cycles -> exactly one r pulse. Release and re-press after full debounce -> exactly one further r pulse.
5. Reset mid-operation: set_raw high, rst_n=0 for one edge at the third debounce count, set_raw still high -> q=0, q_n=1, s=0 during reset. A fresh s pulse arrives DEBOUNCE_CYCLES+2 cycles after rst_n returns to 1.
6. Minimum parameter DEBOUNCE_CYCLES=2: single-cycle glitch rejected; two-cycle high accepted with s 4 cycles after the first sampling edge.
